// File: rtl/cec_seq_ctrl.sv
// ============================================================================
// Module   : cec_seq_ctrl
// Brief    : Two-pass common-exponent sequencer: buffers per-lane product
//            exponents while tracking the vector max, then replays shifts.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cec_seq_ctrl #(
  parameter int LANES      = 10,
  parameter int MAX_CHUNKS = 8,
  parameter int DIFF_SAT   = 31
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [LANES*10-1:0]   in_exp_a,
  input  logic [LANES*10-1:0]   in_exp_b,
  input  logic [LANES-1:0]      in_lane_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [LANES*10-1:0]   out_diff,
  output logic [9:0]            out_max_exp,
  output logic                  overflow
);

  localparam int C_PTR_W = $clog2(MAX_CHUNKS);
  localparam int C_CNT_W = C_PTR_W + 1;

  localparam logic [0:0] S_LOAD  = 1'b0;
  localparam logic [0:0] S_DRAIN = 1'b1;

  localparam logic [9:0]         C_BIAS     = 10'd127;
  localparam logic [9:0]         C_DIFF_SAT = DIFF_SAT[9:0];
  localparam logic [10:0]        C_SAT_EXT  = {1'b0, C_DIFF_SAT};
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(MAX_CHUNKS - 1);

  logic [0:0]          r_state;
  logic [0:0]          w_state_nxt;
  logic [C_PTR_W-1:0]  r_wr_ptr;
  logic [C_CNT_W-1:0]  r_rd_ptr;
  logic [C_CNT_W-1:0]  r_count;
  logic [9:0]          r_max;
  logic                r_max_valid;
  logic                r_overflow;

  logic [LANES*10-1:0] r_buf_exp [MAX_CHUNKS];
  logic [LANES-1:0]    r_buf_en  [MAX_CHUNKS];

  logic                   w_in_fire;
  logic                   w_out_fire;
  logic                   w_chunk_full;
  logic [LANES*10-1:0]    w_e_flat;
  logic [LANES*10-1:0]    w_rd_exp;
  logic [LANES-1:0]       w_rd_en;
  logic [LANES*10-1:0]    w_diff_flat;
  logic [9:0]             w_fold_max;
  logic                   w_fold_valid;

  assign w_in_fire    = in_valid && in_ready;
  assign w_out_fire   = out_valid && out_ready;
  assign w_chunk_full = (r_count == C_CNT_LAST);
  assign w_rd_exp     = r_buf_exp[r_rd_ptr[C_PTR_W-1:0]];
  assign w_rd_en      = r_buf_en[r_rd_ptr[C_PTR_W-1:0]];

  // Per-lane product exponent on the way in, shift amount on the way out.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [9:0]  w_be;
    logic [10:0] w_sub;

    assign w_e_flat[10*gi +: 10] = in_exp_a[10*gi +: 10] + in_exp_b[10*gi +: 10] - C_BIAS;

    assign w_be  = w_rd_exp[10*gi +: 10];
    assign w_sub = {r_max[9], r_max} - {w_be[9], w_be};
    assign w_diff_flat[10*gi +: 10] = !w_rd_en[gi]       ? C_DIFF_SAT :
                                      (w_sub > C_SAT_EXT) ? C_DIFF_SAT : w_sub[9:0];
  end

  always_comb begin
    w_fold_max   = r_max;
    w_fold_valid = r_max_valid;
    for (int i = 0; i < LANES; i++) begin
      if (in_lane_en[i] &&
          (!w_fold_valid || ($signed(w_e_flat[10*i +: 10]) > $signed(w_fold_max)))) begin
        w_fold_max   = w_e_flat[10*i +: 10];
        w_fold_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD:  if (w_in_fire && (in_last || w_chunk_full)) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_out_fire && out_last)                 w_state_nxt = S_LOAD;
      default: w_state_nxt = S_LOAD;
    endcase
  end

  always_comb begin
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    out_diff    = '0;
    out_max_exp = '0;
    overflow    = r_overflow;
    case (r_state)
      S_LOAD: begin
        in_ready = !rst;
      end
      S_DRAIN: begin
        out_valid   = 1'b1;
        out_last    = (r_rd_ptr == (r_count - C_CNT_W'(1)));
        out_diff    = w_diff_flat;
        out_max_exp = r_max_valid ? r_max : 10'd0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_max       <= '0;
      r_max_valid <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_overflow <= 1'b0;
      if (r_state == S_LOAD && w_in_fire) begin
        r_wr_ptr    <= r_wr_ptr + C_PTR_W'(1);
        r_count     <= r_count + C_CNT_W'(1);
        r_max       <= w_fold_max;
        r_max_valid <= w_fold_valid;
        r_overflow  <= w_chunk_full && !in_last;
      end
      if (r_state == S_DRAIN && w_out_fire) begin
        if (out_last) begin
          r_wr_ptr    <= '0;
          r_rd_ptr    <= '0;
          r_count     <= '0;
          r_max_valid <= 1'b0;
        end else begin
          r_rd_ptr <= r_rd_ptr + C_CNT_W'(1);
        end
      end
    end
  end

  // Buffer contents are don't-care until written, so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_buf_exp[r_wr_ptr] <= w_e_flat;
      r_buf_en[r_wr_ptr]  <= in_lane_en;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cec_seq_ctrl.sv
// ============================================================================
// Module   : tb_cec_seq_ctrl
// Brief    : Directed self-checking bench for cec_seq_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cec_seq_ctrl;

  localparam int LANES = 10;
  localparam int W     = LANES * 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             in_last;
  logic [W-1:0]     in_exp_a;
  logic [W-1:0]     in_exp_b;
  logic [LANES-1:0] in_lane_en;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic [W-1:0]     out_diff;
  logic [9:0]       out_max_exp;
  logic             overflow;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cec_seq_ctrl #(.LANES(LANES), .MAX_CHUNKS(8), .DIFF_SAT(31)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_last    (in_last),
    .in_exp_a   (in_exp_a),
    .in_exp_b   (in_exp_b),
    .in_lane_en (in_lane_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .out_diff   (out_diff),
    .out_max_exp(out_max_exp),
    .overflow   (overflow)
  );

  function automatic logic [W-1:0] rep(input logic [9:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < LANES; i++) r[10*i +: 10] = v;
    return r;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [LANES-1:0] en, input logic last);
    check("send_in_ready", in_ready, 1);
    in_valid   = 1'b1;
    in_exp_a   = a;
    in_exp_b   = b;
    in_lane_en = en;
    in_last    = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic recv(input string tag, input logic [W-1:0] ediff,
                      input logic [9:0] emax, input logic elast);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_diff"}, out_diff, ediff);
    check({tag, "_max"}, out_max_exp, emax);
    check({tag, "_last"}, out_last, elast);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    in_exp_a = '0; in_exp_b = '0; in_lane_en = '0;
    tick(); tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_diff", out_diff, 0);
    check("rst_out_max", out_max_exp, 0);
    check("rst_overflow", overflow, 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Two-chunk vector, max comes from lane 3 of the second chunk.
    send(rep(10'd127), rep(10'd127), '1, 1'b0);
    a = rep(10'd127); a[30 +: 10] = 10'd130;
    send(a, rep(10'd127), '1, 1'b1);
    check("t1_turnaround_valid", out_valid, 1);
    check("t1_in_ready_low", in_ready, 0);
    recv("t1_c0", rep(10'd3), 10'd130, 1'b0);
    d = rep(10'd3); d[30 +: 10] = 10'd0;
    recv("t1_c1", d, 10'd130, 1'b1);
    check("t1_in_ready_back", in_ready, 1);
    check("t1_out_valid_low", out_valid, 0);

    // Saturation with a negative product exponent.
    a = rep(10'd500); b = rep(10'd500);
    a[0 +: 10] = 10'd200; b[0 +: 10] = 10'd127;
    a[10 +: 10] = 10'd1;  b[10 +: 10] = 10'd1;
    send(a, b, 10'b00_0000_0011, 1'b1);
    d = rep(10'd31); d[0 +: 10] = 10'd0;
    recv("t2_sat", d, 10'd200, 1'b1);

    // All-negative exponents, then a vector with no enabled lane.
    send(rep(10'd0), rep(10'd0), '1, 1'b1);
    recv("t3_neg", rep(10'd0), 10'h381, 1'b1);
    send(rep(10'd300), rep(10'd300), '0, 1'b1);
    recv("t3_none", rep(10'd31), 10'd0, 1'b1);

    // Backpressure across a 3-chunk drain: E = 100, 110, 120.
    send(rep(10'd100), rep(10'd127), '1, 1'b0);
    send(rep(10'd110), rep(10'd127), '1, 1'b0);
    send(rep(10'd120), rep(10'd127), '1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("t4_hold_valid", out_valid, 1);
      check("t4_hold_diff", out_diff, rep(10'd20));
      check("t4_hold_last", out_last, 0);
      check("t4_hold_max", out_max_exp, 10'd120);
      tick();
    end
    recv("t4_c0", rep(10'd20), 10'd120, 1'b0);
    check("t4_in_ready_c0", in_ready, 0);
    recv("t4_c1", rep(10'd10), 10'd120, 1'b0);
    check("t4_in_ready_c1", in_ready, 0);
    recv("t4_c2", rep(10'd0), 10'd120, 1'b1);
    check("t4_in_ready_done", in_ready, 1);

    // Overflow: eight chunks with no in_last, E = 120..127.
    for (int k = 0; k < 8; k++) begin
      send(rep(10'(120 + k)), rep(10'd127), '1, 1'b0);
      if (k < 7) check("t5_no_ovf_early", overflow, 0);
    end
    check("t5_ovf_pulse", overflow, 1);
    check("t5_in_ready_low", in_ready, 0);
    check("t5_out_valid", out_valid, 1);
    tick();
    check("t5_ovf_cleared", overflow, 0);
    for (int k = 0; k < 8; k++) begin
      recv("t5_drain", rep(10'(7 - k)), 10'd127, (k == 7));
    end
    check("t5_in_ready_done", in_ready, 1);

    // Reset mid-drain after one of four chunks.
    a = rep(10'd127); a[0 +: 10] = 10'd300;
    send(a, rep(10'd127), '1, 1'b0);
    send(rep(10'd127), rep(10'd127), '1, 1'b0);
    send(rep(10'd127), rep(10'd127), '1, 1'b0);
    send(rep(10'd127), rep(10'd127), '1, 1'b1);
    d = rep(10'd31); d[0 +: 10] = 10'd0;
    recv("t6_c0", d, 10'd300, 1'b0);
    rst = 1'b1;
    tick();
    check("t6_rst_out_valid", out_valid, 0);
    check("t6_rst_in_ready", in_ready, 0);
    check("t6_rst_overflow", overflow, 0);
    rst = 1'b0;
    #1;
    check("t6_in_ready_after", in_ready, 1);
    send(rep(10'd127), rep(10'd127), '1, 1'b1);
    recv("t6_new", rep(10'd0), 10'd127, 1'b1);
    check("t6_in_ready_done", in_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
